clk_div_sequencer: RTL and testbench

//   Programmable clock divider with a run/stop controller and a runtime ratio-change handshake.
//   - Generates divided clock `out` from `clk`; divide ratio N is loaded at runtime.
//   - New ratios take effect only on period boundaries, so `out` never glitches or shows a

---
 rtl/clk_div_sequencer_if.sv | 22 ++
 rtl/clk_div_sequencer.sv | 108 ++++++++++
 tb/tb_clk_div_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clk_div_sequencer_if.sv
// Control/config bus of the programmable clock divider.
// The master starts, stops and re-ratios the divider. The slave is the divider itself.
interface clk_div_sequencer_if #(parameter int W = 8);
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         out;
  logic         tick;
  logic         busy;
  logic         err;

  modport master (
    output enable, cfg_valid, cfg_div,
    input  cfg_ready, out, tick, busy, err
  );

  modport slave (
    input  enable, cfg_valid, cfg_div,
    output cfg_ready, out, tick, busy, err
  );
endinterface

// File: rtl/clk_div_sequencer.sv
// Programmable clock divider with a run/stop controller.
// Ratio changes are applied only on period boundaries, so the output never glitches.
module clk_div_sequencer #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input logic               clk,
  input logic               rst,
  clk_div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

  localparam logic [W-1:0] DefDiv = W'(DEFAULT_DIV);

  stateT        state, nextState;
  logic [W-1:0] cnt, nextCnt;
  logic [W-1:0] divActive, nextDiv;
  logic [W-1:0] pendDiv, nextPendDiv;
  logic         pending, nextPending;
  logic         outReg, nextOut;
  logic         tickReg, nextTick;
  logic         errReg, nextErr;
  logic         running, boundary, xfer, legal;

  // Next-state logic. out and tick are derived from the next state so that
  // both leave the register stage together with the counter they describe.
  always_comb begin
    running     = (state != IDLE);
    boundary    = running && (cnt == divActive - W'(1));
    xfer        = bus.cfg_valid && !pending;
    legal       = (bus.cfg_div >= W'(2));

    nextState   = state;
    nextCnt     = cnt;
    nextDiv     = divActive;
    nextPendDiv = pendDiv;
    nextPending = pending;
    nextErr     = xfer && !legal;

    case (state)
      IDLE: begin
        nextCnt = '0;
        if (bus.enable) nextState = RUN;
      end
      default: begin
        // A running period always completes. Dropping enable at the boundary
        // itself stops immediately instead of running one more period.
        if (boundary) begin
          nextCnt   = '0;
          nextState = bus.enable ? RUN : IDLE;
        end else begin
          nextCnt   = cnt + W'(1);
          nextState = bus.enable ? RUN : DRAIN;
        end
      end
    endcase

    // xfer requires !pending, so this never collides with the transfer below.
    if (boundary && pending) begin
      nextDiv     = pendDiv;
      nextPending = 1'b0;
    end

    if (xfer && legal) begin
      if (state == IDLE) begin
        nextDiv = bus.cfg_div;
      end else begin
        nextPendDiv = bus.cfg_div;
        nextPending = 1'b1;
      end
    end

    nextTick = (nextState != IDLE) && (nextCnt == '0);
    nextOut  = (nextState != IDLE) && (nextCnt < (nextDiv >> 1));
  end

  // State and output registers. Reset restores the default ratio and drops any
  // pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      divActive <= DefDiv;
      pendDiv   <= DefDiv;
      pending   <= 1'b0;
      outReg    <= 1'b0;
      tickReg   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      divActive <= nextDiv;
      pendDiv   <= nextPendDiv;
      pending   <= nextPending;
      outReg    <= nextOut;
      tickReg   <= nextTick;
      errReg    <= nextErr;
    end
  end

  assign bus.out       = outReg;
  assign bus.tick      = tickReg;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = errReg;
  assign bus.cfg_ready = !pending;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer. Every cycle is checked against
// hand-computed out/tick/busy/cfg_ready/err values.
module tb_clk_div_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  clk_div_sequencer_if #(.W(8)) bus ();

  clk_div_sequencer #(.W(8), .DEFAULT_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] div);
    bus.enable    = en;
    bus.cfg_valid = valid;
    bus.cfg_div   = div;
  endtask

  // Advance one clock, then check the registered outputs 1 time unit later.
  task automatic expectCycle(input string tag, input logic o, input logic t, input logic b,
                             input logic r, input logic e);
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s.out", tag),       32'(bus.out),       32'(o));
    checkOutput($sformatf("%s.tick", tag),      32'(bus.tick),      32'(t));
    checkOutput($sformatf("%s.busy", tag),      32'(bus.busy),      32'(b));
    checkOutput($sformatf("%s.cfg_ready", tag), 32'(bus.cfg_ready), 32'(r));
    checkOutput($sformatf("%s.err", tag),       32'(bus.err),       32'(e));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    expectCycle("rst0", 0, 0, 0, 1, 0);
    expectCycle("rst1", 0, 0, 0, 1, 0);
    rst = 1'b0;
    expectCycle("idle", 0, 0, 0, 1, 0);

    // T1: default divide-by-2, then stop at end of period
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t1c0", 1, 1, 1, 1, 0);
    expectCycle("t1c1", 0, 0, 1, 1, 0);
    expectCycle("t1c2", 1, 1, 1, 1, 0);
    expectCycle("t1c3", 0, 0, 1, 1, 0);
    expectCycle("t1c4", 1, 1, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    expectCycle("t1drain", 0, 0, 1, 1, 0);
    expectCycle("t1stop",  0, 0, 0, 1, 0);

    // T2: load N=4 while idle, then run
    applyStimulus(1'b0, 1'b1, 8'd4);
    expectCycle("t2load", 0, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t2c0", 1, 1, 1, 1, 0);
    expectCycle("t2c1", 1, 0, 1, 1, 0);
    expectCycle("t2c2", 0, 0, 1, 1, 0);
    expectCycle("t2c3", 0, 0, 1, 1, 0);
    expectCycle("t2c4", 1, 1, 1, 1, 0);
    expectCycle("t2c5", 1, 0, 1, 1, 0);

    // T3: request N=5 at cnt=1, applied at the next boundary
    applyStimulus(1'b1, 1'b1, 8'd5);
    expectCycle("t3c2", 0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t3c3", 0, 0, 1, 0, 0);
    expectCycle("t3n0", 1, 1, 1, 1, 0);
    expectCycle("t3n1", 1, 0, 1, 1, 0);
    expectCycle("t3n2", 0, 0, 1, 1, 0);
    expectCycle("t3n3", 0, 0, 1, 1, 0);
    expectCycle("t3n4", 0, 0, 1, 1, 0);
    expectCycle("t3n5", 1, 1, 1, 1, 0);

    // Back to N=4 for the next tests
    applyStimulus(1'b1, 1'b1, 8'd4);
    expectCycle("t3b1", 1, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t3b2", 0, 0, 1, 0, 0);
    expectCycle("t3b3", 0, 0, 1, 0, 0);
    expectCycle("t3b4", 0, 0, 1, 0, 0);
    expectCycle("t3b5", 1, 1, 1, 1, 0);

    // T4: illegal ratios 1 and 0 are rejected with err, pattern unchanged
    applyStimulus(1'b1, 1'b1, 8'd1);
    expectCycle("t4c1", 1, 0, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 8'd0);
    expectCycle("t4c2", 0, 0, 1, 1, 1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t4c3", 0, 0, 1, 1, 0);
    expectCycle("t4c0", 1, 1, 1, 1, 0);

    // T5: enable drops at cnt=1, period completes, then idle
    expectCycle("t5c1", 1, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    expectCycle("t5c2", 0, 0, 1, 1, 0);
    expectCycle("t5c3", 0, 0, 1, 1, 0);
    expectCycle("t5idle0", 0, 0, 0, 1, 0);
    expectCycle("t5idle1", 0, 0, 0, 1, 0);

    // T5b: drop and re-raise enable inside a period, no gap
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t5r0", 1, 1, 1, 1, 0);
    expectCycle("t5r1", 1, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    expectCycle("t5r2", 0, 0, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t5r3", 0, 0, 1, 1, 0);
    expectCycle("t5r4", 1, 1, 1, 1, 0);
    expectCycle("t5r5", 1, 0, 1, 1, 0);

    // T6: N=5 with pending 3, reset at cnt=2 clears everything
    applyStimulus(1'b1, 1'b1, 8'd5);
    expectCycle("t6a2", 0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t6a3", 0, 0, 1, 0, 0);
    expectCycle("t6n0", 1, 1, 1, 1, 0);
    applyStimulus(1'b1, 1'b1, 8'd3);
    expectCycle("t6n1", 1, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    expectCycle("t6n2", 0, 0, 1, 0, 0);
    rst = 1'b1;
    expectCycle("t6rst", 0, 0, 0, 1, 0);
    rst = 1'b0;
    expectCycle("t6d0", 1, 1, 1, 1, 0);
    expectCycle("t6d1", 0, 0, 1, 1, 0);
    expectCycle("t6d2", 1, 1, 1, 1, 0);
    expectCycle("t6d3", 0, 0, 1, 1, 0);
    expectCycle("t6d4", 1, 1, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
